// File: rtl/counter_pkg.sv
// Shared definitions for the counter stream checker: mode encodings,
// checker state encoding and error-code values.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_UPDOWN = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'b00,
    ST_SYNC   = 2'b01,
    ST_INFER  = 2'b10,
    ST_TRACK  = 2'b11
  } state_e;

  // err_code bit 0 = value mismatch, bit 1 = flag mismatch
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_VAL  = 2'b01;
  localparam logic [1:0] ERR_FLAG = 2'b10;
  localparam logic [1:0] ERR_BOTH = 2'b11;

endpackage

// File: rtl/counter_stream_checker_if.sv
// Observation/status bundle between a counter source and the stream checker.
//   en, mode, count_in, limit_in : observed counter stream (source -> checker)
//   locked, dir_out, err_pulse, err_code, err_count : checker status
interface counter_stream_checker_if #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned ERR_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [CNT_W-1:0] count_in;
  logic             limit_in;
  logic             locked;
  logic             dir_out;
  logic             err_pulse;
  logic [1:0]       err_code;
  logic [ERR_W-1:0] err_count;

  modport master (
    output en, mode, count_in, limit_in,
    input  locked, dir_out, err_pulse, err_code, err_count
  );

  modport slave (
    input  en, mode, count_in, limit_in,
    output locked, dir_out, err_pulse, err_code, err_count
  );
endinterface

// File: rtl/counter_expect.sv
// Combinational next-state model of the multi-mode counter.
//   prev_i     : last observed count
//   mode_i     : counter mode
//   dir_i      : current bounce direction (1 = up), used in up/down mode
//   exp_val_o  : expected next count
//   exp_flag_o : expected boundary flag
//   next_dir_o : bounce direction after this step
module counter_expect
  import counter_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic [CNT_W-1:0] prev_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  output logic [CNT_W-1:0] exp_val_o,
  output logic             exp_flag_o,
  output logic             next_dir_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = '0;

  // Saturate at the limits instead of wrapping; the flag marks the stall.
  always_comb begin
    exp_val_o  = prev_i;
    exp_flag_o = 1'b0;
    next_dir_o = dir_i;
    case (mode_i)
      MODE_UP: begin
        if (prev_i == CNT_MAX) exp_flag_o = 1'b1;
        else                   exp_val_o  = prev_i + CNT_W'(1);
      end
      MODE_DOWN: begin
        if (prev_i == CNT_MIN) exp_flag_o = 1'b1;
        else                   exp_val_o  = prev_i - CNT_W'(1);
      end
      MODE_UPDOWN: begin
        if (dir_i) begin
          if (prev_i == CNT_MAX) begin
            exp_flag_o = 1'b1;
            next_dir_o = 1'b0;
          end else begin
            exp_val_o = prev_i + CNT_W'(1);
          end
        end else begin
          if (prev_i == CNT_MIN) begin
            exp_flag_o = 1'b1;
            next_dir_o = 1'b1;
          end else begin
            exp_val_o = prev_i - CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/counter_stream_checker.sv
// Receive-side monitor for the multi-mode counter. Tracks the expected
// next (value, flag) pair and reports every deviation.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of counter_stream_checker_if (observations in,
//              lock/direction/error status out)
module counter_stream_checker
  import counter_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned ERR_W = 8
) (
  input logic                     clk,
  input logic                     rst,
  counter_stream_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [CNT_W-1:0] exp_val;
  logic             exp_flag;
  logic             next_dir;

  counter_expect #(.CNT_W(CNT_W)) u_expect (
    .prev_i     (prev_q),
    .mode_i     (mode_q),
    .dir_i      (dir_q),
    .exp_val_o  (exp_val),
    .exp_flag_o (exp_flag),
    .next_dir_o (next_dir)
  );

  // Direction inference for bounce mode from two consecutive samples.
  logic up_ok, dn_ok, top_ok, bot_ok, infer_ok, infer_dir;
  always_comb begin
    up_ok     = (prev_q != CNT_MAX) && (bus.count_in == prev_q + CNT_W'(1));
    dn_ok     = (prev_q != CNT_MIN) && (bus.count_in == prev_q - CNT_W'(1));
    top_ok    = (bus.count_in == prev_q) && (prev_q == CNT_MAX) && bus.limit_in;
    bot_ok    = (bus.count_in == prev_q) && (prev_q == CNT_MIN) && bus.limit_in;
    infer_ok  = up_ok | dn_ok | top_ok | bot_ok;
    infer_dir = up_ok | bot_ok;
  end

  logic val_mis, flag_mis;
  assign val_mis  = (bus.count_in != exp_val);
  assign flag_mis = (bus.limit_in != exp_flag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNSYNC;
      prev_q      <= '0;
      mode_q      <= 2'b00;
      dir_q       <= 1'b1;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state: prev and mode always follow the observation, so a single
  // glitch costs exactly one error. SYNC is the unlocked re-capture step
  // after a mode change into a non-bounce mode.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    if (bus.en) begin
      prev_d = bus.count_in;
      mode_d = bus.mode;
      case (state_q)
        ST_UNSYNC, ST_SYNC: begin
          state_d = (bus.mode == MODE_UPDOWN) ? ST_INFER : ST_TRACK;
        end
        default: begin
          if (bus.mode != mode_q) begin
            state_d = (bus.mode == MODE_UPDOWN) ? ST_INFER : ST_SYNC;
          end else if (state_q == ST_INFER) begin
            if (infer_ok) begin
              state_d = ST_TRACK;
              dir_d   = infer_dir;
            end
          end else begin
            dir_d = next_dir;
            if (val_mis || flag_mis) begin
              err_pulse_d = 1'b1;
              err_code_d  = {flag_mis, val_mis};
              err_count_d = (&err_count_q) ? err_count_q : err_count_q + ERR_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.locked    = (state_q == ST_TRACK);
  assign bus.dir_out   = dir_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_counter_stream_checker.sv
module tb_counter_stream_checker;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  counter_stream_checker_if #(.CNT_W(4), .ERR_W(8)) bus ();

  counter_stream_checker #(.CNT_W(4), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock with the given stream sample; outputs are sampled 1ns after the edge.
  task automatic step(input logic e, input logic [1:0] m, input logic [3:0] c, input logic l);
    bus.en       = e;
    bus.mode     = m;
    bus.count_in = c;
    bus.limit_in = l;
    @(posedge clk);
    #1;
  endtask

  // Reset with en held high to show reset wins.
  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 2'b00, 4'd7, 1'b1);
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
    chk({tag, "_dir"},    32'(bus.dir_out), 32'd1);
    chk({tag, "_pulse"},  32'(bus.err_pulse), 32'd0);
    chk({tag, "_code"},   32'(bus.err_code), 32'd0);
    chk({tag, "_count"},  32'(bus.err_count), 32'd0);
  endtask

  initial begin
    n_total      = 0;
    n_bad        = 0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.mode     = 2'b00;
    bus.count_in = 4'd0;
    bus.limit_in = 1'b0;
    @(posedge clk);
    do_reset();
    chk_reset_state("por");

    // Mode 00 full ramp then stall at MAX
    step(1'b1, 2'b00, 4'd0, 1'b0);
    chk("up_lock_first", 32'(bus.locked), 32'd1);
    for (int i = 1; i < 16; i++) begin
      step(1'b1, 2'b00, 4'(i), 1'b0);
      chk("up_ramp_pulse", 32'(bus.err_pulse), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00, 4'd15, 1'b1);
      chk("up_stall_pulse", 32'(bus.err_pulse), 32'd0);
    end
    chk("up_count", 32'(bus.err_count), 32'd0);
    chk("up_code", 32'(bus.err_code), 32'd0);
    chk("up_locked", 32'(bus.locked), 32'd1);

    // Mode 01 down to 0, stall, single glitch
    do_reset();
    step(1'b1, 2'b01, 4'd3, 1'b0);
    step(1'b1, 2'b01, 4'd2, 1'b0);
    step(1'b1, 2'b01, 4'd1, 1'b0);
    step(1'b1, 2'b01, 4'd0, 1'b0);
    step(1'b1, 2'b01, 4'd0, 1'b1);
    chk("dn_clean_count", 32'(bus.err_count), 32'd0);
    step(1'b1, 2'b01, 4'd5, 1'b1);
    chk("dn_glitch_pulse", 32'(bus.err_pulse), 32'd1);
    chk("dn_glitch_code", 32'(bus.err_code), 32'd1);
    chk("dn_glitch_count", 32'(bus.err_count), 32'd1);
    step(1'b0, 2'b01, 4'd9, 1'b0);
    chk("dn_idle_pulse", 32'(bus.err_pulse), 32'd0);
    chk("dn_idle_count", 32'(bus.err_count), 32'd1);
    step(1'b1, 2'b01, 4'd4, 1'b0);
    chk("dn_recover_pulse", 32'(bus.err_pulse), 32'd0);
    chk("dn_recover_count", 32'(bus.err_count), 32'd1);
    chk("dn_code_held", 32'(bus.err_code), 32'd1);

    // Mode 10 bounce at the top
    do_reset();
    step(1'b1, 2'b10, 4'd14, 1'b0);
    chk("ud_infer_locked", 32'(bus.locked), 32'd0);
    step(1'b1, 2'b10, 4'd15, 1'b0);
    chk("ud_lock", 32'(bus.locked), 32'd1);
    chk("ud_dir_up", 32'(bus.dir_out), 32'd1);
    step(1'b1, 2'b10, 4'd15, 1'b1);
    chk("ud_flip_dir", 32'(bus.dir_out), 32'd0);
    chk("ud_flip_pulse", 32'(bus.err_pulse), 32'd0);
    step(1'b1, 2'b10, 4'd14, 1'b0);
    step(1'b1, 2'b10, 4'd13, 1'b0);
    chk("ud_dir_down", 32'(bus.dir_out), 32'd0);
    chk("ud_count", 32'(bus.err_count), 32'd0);

    // Mode 00 at MAX with missing flag
    do_reset();
    step(1'b1, 2'b00, 4'd14, 1'b0);
    step(1'b1, 2'b00, 4'd15, 1'b0);
    step(1'b1, 2'b00, 4'd15, 1'b0);
    chk("flag_pulse", 32'(bus.err_pulse), 32'd1);
    chk("flag_code", 32'(bus.err_code), 32'd2);
    chk("flag_count", 32'(bus.err_count), 32'd1);

    // Switch to hold, then force 300 value mismatches
    step(1'b1, 2'b11, 4'd0, 1'b0);
    chk("hold_switch_pulse", 32'(bus.err_pulse), 32'd0);
    chk("hold_switch_locked", 32'(bus.locked), 32'd0);
    step(1'b1, 2'b11, 4'd0, 1'b0);
    step(1'b1, 2'b11, 4'd0, 1'b0);
    chk("hold_steady_count", 32'(bus.err_count), 32'd1);
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 2'b11, 4'(i & 1), 1'b0);
      if (i == 254) chk("sat_reach", 32'(bus.err_count), 32'd255);
    end
    chk("sat_count", 32'(bus.err_count), 32'd255);
    chk("sat_pulse", 32'(bus.err_pulse), 32'd1);
    chk("sat_code", 32'(bus.err_code), 32'd1);

    // Mid-stream mode switch, then reset
    do_reset();
    chk_reset_state("mid_rst");
    step(1'b1, 2'b00, 4'd5, 1'b0);
    step(1'b1, 2'b00, 4'd6, 1'b0);
    step(1'b1, 2'b00, 4'd9, 1'b0);
    chk("sw_pre_count", 32'(bus.err_count), 32'd1);
    step(1'b1, 2'b00, 4'd10, 1'b0);
    step(1'b1, 2'b01, 4'd9, 1'b0);
    chk("sw_pulse", 32'(bus.err_pulse), 32'd0);
    chk("sw_locked", 32'(bus.locked), 32'd0);
    chk("sw_count", 32'(bus.err_count), 32'd1);
    do_reset();
    chk_reset_state("post_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_stream_checker.md
Name: counter_stream_checker

Overview:
Receive-side monitor for the multi-mode 4-bit counter. It samples the counter's value and boundary flag and tracks the counter's expected next state for the active mode. It flags every deviation in value or flag and keeps a saturating error tally. It sits beside the counter in the same tile and is used for self-check and silicon bring-up.

Parameters:
CNT_W, 4, width of observed count; limits are 0 and 2**CNT_W-1
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  clock; the block uses one clock
rst  input  1  reset; synchronous and active-high
en  input  1  sample strobe; one observation per cycle when high
mode  input  2  mode the counter is running: 00 up, 01 down, 10 up/down bounce, 11 hold
count_in  input  CNT_W  observed counter value
limit_in  input  1  observed boundary flag
locked  output  1  high while in TRACK
dir_out  output  1  tracked direction (1 = up); meaningful in mode 10 only
err_pulse  output  1  one-cycle pulse on a mismatched sample
err_code  output  2  01 value mismatch, 10 flag mismatch, 11 both; held until next error or reset
err_count  output  ERR_W  saturating mismatch count

Behaviour:
- Reset (rst high at a clk edge): state=UNSYNC, locked=0, dir_out=1, err_pulse=0, err_code=00, err_count=0, prev and mode registers cleared. Reset overrides en.
- All state advances only on clk edges with en=1. With en=0, everything holds except err_pulse, which drops to 0.
- States: UNSYNC, SYNC, INFER, TRACK.
- UNSYNC: capture count_in into prev and mode into mode_q. Go to INFER if mode=10, else TRACK. No error check in this state.
- INFER (mode 10 only): compare count_in with prev.
  - count_in=prev+1: dir=1.
  - count_in=prev-1: dir=0.
  - count_in=prev=MAX with limit_in=1: dir=0.
  - count_in=prev=0 with limit_in=1: dir=1.
  - Any other result: no lock, capture a new prev, stay in INFER.
  - On success go to TRACK. INFER never raises errors.
- TRACK: compute the expected (value, flag) from prev and mode_q.
  - 00: prev<MAX gives (prev+1, 0); prev=MAX gives (MAX, 1).
  - 01: prev>0 gives (prev-1, 0); prev=0 gives (0, 1).
  - 10, dir=1: prev<MAX gives (prev+1, 0); prev=MAX gives (MAX, 1) and dir becomes 0.
  - 10, dir=0: prev>0 gives (prev-1, 0); prev=0 gives (0, 1) and dir becomes 1.
  - 11: (prev, 0).
- On mismatch: err_pulse=1 in the cycle after the sample edge, err_code set, err_count+1 saturating at all-ones.
- prev always takes the observed count_in, not the expected value, so a single glitch costs exactly one error.
- dir is resolved from the expectation, not the observation.
- Mode change: if a sampled mode differs from mode_q, do no check that cycle and clear locked. Capture prev and mode_q. Go to INFER if the new mode is 10, else TRACK on the next sample.
- No arithmetic wrap is ever expected: MAX+1 and 0-1 are impossible in every expectation.
- Reset mid-operation: identical to power-on reset, including err_count.

Decomposition:
- Package counter_pkg holds:
  - mode encodings MODE_UP, MODE_DOWN, MODE_UPDOWN, MODE_HOLD
  - state enum
  - err_code constants
- Sub-module counter_expect: purely combinational. Inputs prev, mode, dir. Outputs exp_val, exp_flag, next_dir. It is shared with a future counter model used in the bench.

Test Plan:
- Mode 00, en=1, feed 0..15, then 15/flag=1 ×3 -> locked=1 after the first sample, err_count=0, err_code=00.
- Mode 01 from 3: 3,2,1,0, then 0/flag=1, then inject 5 -> single err_pulse, err_code=01, err_count=1; next correct sample 4 gives no error.
- Mode 10 from 14: 14,15, then 15/flag=1, 14, 13 -> INFER sets dir_out=1, flips to 0 at 15, no errors.
- Mode 00 at 15 with flag=0 -> err_code=10, err_count=1.
- Force 300 mismatches -> err_count saturates at 255, no wrap.
- Switch mode 00→01 mid-stream, then assert rst -> no error on the mode-switch sample; after rst, all outputs return to reset values and locked=0.
